// File: rtl/coreport_arb.sv
// ---------------------------------------------------------------------------
// coreport_arb
//
// Purpose:
//   Two-master, one-slave Wishbone arbiter in front of a GPIO port slave.
//   A round-robin FSM grants the shared slave to one master at a time and
//   keeps that grant (bus lock) for as long as the master holds cyc high.
//   While a master is granted, its request signals are routed
//   combinationally to the slave, and the slave response is routed back.
//   The other master sees all-zero responses.
//
// Optional feature:
//   Define COREPORT_ARB_TIMEOUT_EN to include an 8-bit stall counter. When
//   the granted master has been stalled for TIMEOUT cycles, the arbiter
//   issues a one-cycle error to that master and releases the bus. With the
//   macro undefined there is no counter, and a grant may be held forever.
//
// Parameters:
//   WIDTH    data width of both masters and the slave
//   TIMEOUT  stall limit in cycles, 1..255 (used only with the macro)
//
// Ports:
//   wb_clk, wb_rst_n          clock and synchronous active-low reset
//   mN_adr_i/dat_i/we_i/
//   mN_cyc_i/stb_i            master N request side (N = 0, 1)
//   mN_dat_o/ack_o/err_o      master N response side
//   s_adr_o/dat_o/we_o/
//   s_cyc_o/stb_o             slave request side
//   s_dat_i/ack_i/err_i       slave response side
//   gnt                       one-hot grant: 01 master 0, 10 master 1, 00 idle
// ---------------------------------------------------------------------------
module coreport_arb #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,

    input  logic [31:0]      m0_adr_i,
    input  logic [WIDTH-1:0] m0_dat_i,
    input  logic             m0_we_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic [WIDTH-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic [31:0]      m1_adr_i,
    input  logic [WIDTH-1:0] m1_dat_i,
    input  logic             m1_we_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic [WIDTH-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic [31:0]      s_adr_o,
    output logic [WIDTH-1:0] s_dat_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [WIDTH-1:0] s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,

    output logic [1:0]       gnt
);

    // The state encoding doubles as the one-hot grant vector, so gnt comes
    // straight from the state register.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t r_state;
    logic   r_lst;       // last master served; the other one wins a tie
    logic   w_timeout;   // granted master stalled too long this cycle

    // Reject an out-of-range stall limit at elaboration time.
    generate
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_badTimeout
            $error("coreport_arb: TIMEOUT must be in 1..255");
        end
    endgenerate

`ifdef COREPORT_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       w_stbSel;
    logic       w_stall;

    // A stalled cycle is a granted cycle with stb high and no slave reply.
    // The timeout fires on the TIMEOUT-th such cycle; an ack or err in that
    // same cycle is not a stall, so the reply wins over the timeout.
    always_comb begin
        w_stbSel = 1'b0;
        if (r_state == GNT0) begin
            w_stbSel = m0_stb_i;
        end else if (r_state == GNT1) begin
            w_stbSel = m1_stb_i;
        end
        w_stall   = w_stbSel & ~s_ack_i & ~s_err_i;
        w_timeout = w_stall && (r_cnt == 8'(TIMEOUT - 1));
    end

    // Stall counter: held at zero while idle so every grant starts fresh,
    // cleared by any slave reply, and advanced on each stalled cycle.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            r_cnt <= 8'd0;
        end else if (r_state == IDLE || s_ack_i || s_err_i) begin
            r_cnt <= 8'd0;
        end else if (w_stall) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Arbitration FSM. A grant lasts while the owner keeps cyc high; when
    // cyc is seen low (or the stall limit hits) the bus returns to IDLE for
    // one cycle and the owner is recorded as last served.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            r_state <= IDLE;
            r_lst   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        r_state <= r_lst ? GNT0 : GNT1;
                    end else if (m0_cyc_i) begin
                        r_state <= GNT0;
                    end else if (m1_cyc_i) begin
                        r_state <= GNT1;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i || w_timeout) begin
                        r_state <= IDLE;
                        r_lst   <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i || w_timeout) begin
                        r_state <= IDLE;
                        r_lst   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt = r_state;

    // Bus routing. Everything defaults to zero, which is the idle picture
    // and also what the non-granted master sees. A timeout pulls the slave
    // strobes low and turns into an error for the owning master.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (r_state)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i & ~w_timeout;
                s_stb_o  = m0_stb_i & ~w_timeout;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i & m0_stb_i;
                m0_err_o = (s_err_i & m0_stb_i) | w_timeout;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i & ~w_timeout;
                s_stb_o  = m1_stb_i & ~w_timeout;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i & m1_stb_i;
                m1_err_o = (s_err_i & m1_stb_i) | w_timeout;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/coreport_arb.md
COREPORT_ARB -- requirements
Module: coreport_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of both masters and the slave.
REQ-002 SHALL have parameter TIMEOUT, default 255, bus-stall limit in cycles (range 1..255).
REQ-003 SHALL have port wb_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have, for each master N in {0,1}: mN_adr_i in 32, mN_dat_i in WIDTH, mN_we_i in 1, mN_cyc_i in 1, mN_stb_i in 1, mN_dat_o out WIDTH, mN_ack_o out 1, mN_err_o out 1.
REQ-006 SHALL have slave ports s_adr_o out 32, s_dat_o out WIDTH, s_we_o out 1, s_cyc_o out 1, s_stb_o out 1, s_dat_i in WIDTH, s_ack_i in 1, s_err_i in 1, connecting one Wishbone GPIO port slave.
REQ-007 SHALL have port gnt, output, 2, one-hot current grant: bit0 master 0, bit1 master 1, 00 idle.

Function
REQ-008 SHALL implement states IDLE, GNT0, GNT1; gnt = 00/01/10 respectively.
REQ-009 In IDLE, with only mN_cyc_i high, SHALL enter GNTN next cycle.
REQ-010 In IDLE, with both cyc high, SHALL grant the master not recorded in last-served register lst (round-robin).
REQ-011 In IDLE, with no cyc high, SHALL remain IDLE.
REQ-012 In GNTN, SHALL drive s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o combinationally from master N.
REQ-013 In GNTN, SHALL drive mN_dat_o = s_dat_i, mN_ack_o = s_ack_i & mN_stb_i, mN_err_o = s_err_i & mN_stb_i.
REQ-014 The non-granted master SHALL see dat_o = 0, ack_o = 0, err_o = 0, regardless of its cyc/stb.
REQ-015 In IDLE, all s_* outputs SHALL be 0 and all mN_ack_o/mN_err_o/mN_dat_o 0.
REQ-016 Grant SHALL be held while mN_cyc_i stays high (bus locking across multiple stb beats); no preemption.
REQ-017 When mN_cyc_i is sampled low in GNTN, SHALL return to IDLE next cycle and set lst = N.
REQ-018 Arbitration latency SHALL be exactly one cycle from cyc rise (in IDLE) to s_cyc_o rise; one IDLE cycle SHALL separate consecutive grants.
REQ-019 A master dropping cyc in the same cycle it is granted SHALL still cause one GNT cycle with s_cyc_o low, then IDLE.

Reset
REQ-020 While wb_rst_n is low at a clock edge: state = IDLE, lst = 1 (master 0 wins first contention), timeout counter = 0.
REQ-021 Consequently all outputs SHALL be 0 the cycle after reset is sampled; reset mid-grant SHALL abort the transfer with no ack or err issued.

Configuration
REQ-022 Macro COREPORT_ARB_TIMEOUT_EN SHALL, when defined, include an 8-bit stall counter.
REQ-023 With macro: counter clears on grant entry and on any s_ack_i/s_err_i; increments each GNT cycle with s_stb_o high and no ack/err.
REQ-024 With macro: when counter reaches TIMEOUT, SHALL assert mN_err_o for exactly one cycle, force s_cyc_o/s_stb_o low that cycle, set lst = N, enter IDLE next cycle.
REQ-025 With macro: s_ack_i arriving in the same cycle as timeout SHALL win (ack delivered, no err, counter cleared).
REQ-026 Without macro: no counter, no generated err; mN_err_o is only the routed s_err_i; grant may be held indefinitely.

Verification
REQ-027 Reset then m0 cyc/stb write adr 0x00 dat 0xA5 -> gnt=01 one cycle later, s_adr_o=0x00, s_dat_o=0xA5, m0_ack_o follows s_ack_i, m1 sees ack 0.
REQ-028 Both cyc rise same cycle after reset -> gnt=01 first; after m0 drops cyc, one IDLE cycle, then gnt=10.
REQ-029 Both masters continuously requesting, 4 single-beat transactions each -> grants alternate 01,10,01,10 with one IDLE cycle between.
REQ-030 m1 holds cyc for 3 stb beats (reads 0x04, 0x08, 0x0C) while m0 requests -> gnt stays 10 for all beats; m0 ack 0 throughout.
REQ-031 Macro defined, TIMEOUT=4, slave never acks -> m0_err_o high for one cycle on 4th stalled cycle, s_cyc_o low that cycle, then IDLE; macro undefined -> gnt stays 01 indefinitely.
REQ-032 wb_rst_n low during GNT1 with stb high -> next cycle gnt=00, s_cyc_o=0, m1_ack_o=0, m1_err_o=0; after release m0 wins a simultaneous request.
